tlc_txn_checker: RTL and testbench
==================================

Name: tlc_txn_checker

Overview:
- Passive, parametrised TileLink-C transaction checker for one cache agent (d$ or i$) in the tl-test environment.
- Observes all five channels and tracks outstanding transactions:
  - Acquire -> Grant -> GrantAck
  - Release -> ReleaseAck
  - Probe -> ProbeAck
- Flags protocol violations and stalled transactions in sticky error registers.
- Optionally prints each handshake to the log.

Parameters:
- SOURCE_W, 6, width of a/c/d source; source table has 2^SOURCE_W entries.
- SINK_W, 6, width of d_sink/e_sink; sink table has 2^SINK_W entries.
- ADDR_W, 36, address width.
- DATA_W, 256, beat data width.
- PROBE_MAX, 15, maximum outstanding probes; probe counter width is clog2(PROBE_MAX+1).
- TIMEOUT, 5000, cycles a source entry may stay busy before err_timeout; 0 disables the check.
- PRINT_EN, 1, enables $write logging of every fire; has no effect on checking logic.

Ports:
- clock input 1 system clock
- reset_n input 1 asynchronous active-low reset
- core_id input 64 core index, used in log lines only
- cache_type input 1 0=d$, 1=i$, used in log lines only
- a_opcode/a_param input 3/3; a_source input SOURCE_W; a_address input ADDR_W; a_valid/a_ready input 1/1
- b_opcode/b_param input 3/2; b_address input ADDR_W; b_valid/b_ready input 1/1
- c_opcode/c_param input 3/3; c_source input SOURCE_W; c_address input ADDR_W; c_data input DATA_W; c_valid/c_ready input 1/1
- d_opcode/d_param input 3/2; d_source input SOURCE_W; d_sink input SINK_W; d_data input DATA_W; d_valid/d_ready input 1/1
- e_sink input SINK_W; e_valid/e_ready input 1/1
- err_clr input 1 clears err_vec and first-error capture
- err_vec output 8 sticky error bits:
  - [0] dup_source
  - [1] unexpected_d
  - [2] dup_sink
  - [3] unexpected_e
  - [4] unexpected_probeack
  - [5] probe_overflow
  - [6] bad_opcode
  - [7] timeout
- first_err_valid output 1 first error since reset/clear has been captured
- first_err_code output 3 index of the lowest set bit among the errors raised in the capturing cycle
- first_err_src output SOURCE_W source (or sink, for bits 2/3) of the first error
- acq_cnt output SOURCE_W+1 source entries in ACQ
- rel_cnt output SOURCE_W+1 source entries in REL
- gack_cnt output SINK_W+1 busy sink entries
- probe_cnt output clog2(PROBE_MAX+1) outstanding probes

Behaviour:
- Fire: X_valid && X_ready sampled at posedge clock.
- Pre-cycle state: all checks in a cycle evaluate against the state registered before that edge.
- Reset (async assert, sync use):
  - all source entries IDLE, all sink entries free, age counters 0
  - all counters 0, err_vec 0, first_err_valid 0, first_err_code 0, first_err_src 0
- Source table, per entry:
  - state IDLE/ACQ/REL
  - 16-bit age counter, saturating
  - age resets to 0 on entering ACQ or REL; increments each cycle while not IDLE
- A fire:
  - opcode 6/7 with entry IDLE -> ACQ
  - opcode 6/7 with entry non-IDLE -> err[0]; state unchanged
  - any other opcode -> err[6]
- C fire:
  - opcode 6/7 (Release/ReleaseData), entry IDLE -> REL; non-IDLE -> err[0]
  - opcode 4/5 (ProbeAck/Data), probe_cnt>0 -> decrement; probe_cnt==0 -> err[4]
  - other opcodes -> err[6]
- B fire: probe_cnt increments; at PROBE_MAX it holds and sets err[5].
- D fire:
  - opcode 4/5 (Grant/GrantData):
    - source entry ACQ -> IDLE, else err[1]
    - independently, sink entry free -> busy, else err[2]
  - opcode 6 (ReleaseAck): source entry REL -> IDLE, else err[1]
  - other opcodes -> err[6]
- E fire: sink entry busy -> free, else err[3].
- Same-cycle events:
  - B fire and ProbeAck fire together: probe_cnt unchanged, no error.
  - A or C-Release and D on the same source: D frees the entry; the new request sees a busy entry and raises err[0]; entry ends IDLE.
  - D-Grant and E on the same sink: E sees a free entry and raises err[3]; the sink ends busy.
- Timeout (TIMEOUT>0): an entry whose age equals TIMEOUT sets err[7]. Fires once per busy period because the age increments past TIMEOUT before saturation.
- Simultaneous timeouts: only the lowest-index source is captured in first_err_src.
- Error capture:
  - err_vec bits are sticky.
  - err_clr zeroes err_vec and first_err_valid; a new error in the same cycle wins and is captured.
  - first_err_* is written only when first_err_valid==0.
- Counters are combinational popcounts of the tables, or equivalent registered counts that are exact every cycle.
- Checker outputs have no combinational path from channel inputs; all outputs are registered.
- Logging (PRINT_EN):
  - one line per fire: "INTF: core <id> d$:/i$: [X][Opcode Param] @0x<addr> source: sink: data:"
  - any error sets a line prefixed "ERR:" in the same cycle.

Test Plan:
- AcquireBlock NtoT src 3 -> next cycle acq_cnt=1 -> GrantData src 3 sink 5 -> acq_cnt=0, gack_cnt=1 -> GrantAck sink 5 -> gack_cnt=0, err_vec=0.
- Two AcquirePerm on src 7 without a Grant in between -> err_vec[0]=1, first_err_code=0, first_err_src=7, acq_cnt stays 1.
- ReleaseData src 2 then ReleaseAck src 2 -> rel_cnt goes 1 then 0; a second ReleaseAck on src 2 -> err_vec[1]=1.
- 16 probes with PROBE_MAX=15 -> probe_cnt=15, err_vec[5]=1; then a ProbeAck with a simultaneous B fire -> probe_cnt stays 15.
- TIMEOUT=20, Acquire src 1 with no Grant -> err_vec[7] asserts 21 cycles after the fire; err_clr pulse -> err_vec=0 and no re-fire of err_vec[7].
- Assert reset_n low mid-transaction with acq_cnt=2, gack_cnt=1 -> all counters and err_vec read 0 immediately (asynchronously), before any clock edge.

Source files
------------

// File: rtl/tlc_txn_checker_if.sv
// TileLink-C five-channel bundle observed by tlc_txn_checker.
//   master  : client-side view (drives A/C/E requests and B/D ready)
//   slave   : manager-side view (drives B/D responses and A/C/E ready)
//   monitor : passive view, every signal is an input
interface tlc_txn_checker_if #(
  parameter int unsigned SOURCE_W = 6,
  parameter int unsigned SINK_W   = 6,
  parameter int unsigned ADDR_W   = 36,
  parameter int unsigned DATA_W   = 256
);
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic                a_valid;
  logic                a_ready;

  logic [2:0]          b_opcode;
  logic [1:0]          b_param;
  logic [ADDR_W-1:0]   b_address;
  logic                b_valid;
  logic                b_ready;

  logic [2:0]          c_opcode;
  logic [2:0]          c_param;
  logic [SOURCE_W-1:0] c_source;
  logic [ADDR_W-1:0]   c_address;
  logic [DATA_W-1:0]   c_data;
  logic                c_valid;
  logic                c_ready;

  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [SOURCE_W-1:0] d_source;
  logic [SINK_W-1:0]   d_sink;
  logic [DATA_W-1:0]   d_data;
  logic                d_valid;
  logic                d_ready;

  logic [SINK_W-1:0]   e_sink;
  logic                e_valid;
  logic                e_ready;

  modport master (
    output a_opcode, a_param, a_source, a_address, a_valid,
    input  a_ready,
    input  b_opcode, b_param, b_address, b_valid,
    output b_ready,
    output c_opcode, c_param, c_source, c_address, c_data, c_valid,
    input  c_ready,
    input  d_opcode, d_param, d_source, d_sink, d_data, d_valid,
    output d_ready,
    output e_sink, e_valid,
    input  e_ready
  );

  modport slave (
    input  a_opcode, a_param, a_source, a_address, a_valid,
    output a_ready,
    output b_opcode, b_param, b_address, b_valid,
    input  b_ready,
    input  c_opcode, c_param, c_source, c_address, c_data, c_valid,
    output c_ready,
    output d_opcode, d_param, d_source, d_sink, d_data, d_valid,
    input  d_ready,
    input  e_sink, e_valid,
    output e_ready
  );

  modport monitor (
    input a_opcode, a_param, a_source, a_address, a_valid, a_ready,
    input b_opcode, b_param, b_address, b_valid, b_ready,
    input c_opcode, c_param, c_source, c_address, c_data, c_valid, c_ready,
    input d_opcode, d_param, d_source, d_sink, d_data, d_valid, d_ready,
    input e_sink, e_valid, e_ready
  );
endinterface

// File: rtl/tlc_txn_checker.sv
// Passive TileLink-C transaction checker for one cache agent.
// Tracks Acquire/Grant/GrantAck, Release/ReleaseAck and Probe/ProbeAck and
// raises sticky error bits on protocol violations or stalled sources.
// Ports:
//   clock, reset_n       : clock, async active-low reset
//   core_id, cache_type  : identification for log lines only
//   tl                   : monitor view of the five TL-C channels
//   err_clr              : clears err_vec and the first-error capture
//   err_vec              : sticky error bits (see Err* indices below)
//   first_err_*          : code/source of the first error since reset/clear
//   acq_cnt, rel_cnt     : source entries in ACQ / REL
//   gack_cnt, probe_cnt  : busy sink entries / outstanding probes
module tlc_txn_checker #(
  parameter int unsigned SOURCE_W  = 6,
  parameter int unsigned SINK_W    = 6,
  parameter int unsigned ADDR_W    = 36,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned PROBE_MAX = 15,
  parameter int unsigned TIMEOUT   = 5000,
  parameter bit          PRINT_EN  = 1'b1,
  localparam int unsigned ProbeW   = $clog2(PROBE_MAX + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [63:0]         core_id,
  input  logic                cache_type,
  tlc_txn_checker_if.monitor  tl,
  input  logic                err_clr,
  output logic [7:0]          err_vec,
  output logic                first_err_valid,
  output logic [2:0]          first_err_code,
  output logic [SOURCE_W-1:0] first_err_src,
  output logic [SOURCE_W:0]   acq_cnt,
  output logic [SOURCE_W:0]   rel_cnt,
  output logic [SINK_W:0]     gack_cnt,
  output logic [ProbeW-1:0]   probe_cnt
);

  localparam int NumSrc  = 2 ** SOURCE_W;
  localparam int NumSink = 2 ** SINK_W;
  localparam int SrcCntW = SOURCE_W + 1;
  localparam int SnkCntW = SINK_W + 1;

  localparam int ErrDupSrc   = 0;
  localparam int ErrUnexpD   = 1;
  localparam int ErrDupSink  = 2;
  localparam int ErrUnexpE   = 3;
  localparam int ErrUnexpPa  = 4;
  localparam int ErrProbeOvf = 5;
  localparam int ErrBadOp    = 6;
  localparam int ErrTimeout  = 7;

  typedef enum logic [1:0] {StIdle, StAcq, StRel} src_st_e;

  src_st_e             src_st_q [NumSrc];
  src_st_e             src_st_d [NumSrc];
  logic [15:0]         age_q    [NumSrc];
  logic [15:0]         age_d    [NumSrc];
  logic [NumSink-1:0]  sink_busy_q, sink_busy_d;
  logic [ProbeW-1:0]   probe_q, probe_d;
  logic [7:0]          err_vec_q, err_vec_d;
  logic                first_err_valid_q, first_err_valid_d;
  logic [2:0]          first_err_code_q, first_err_code_d;
  logic [SOURCE_W-1:0] first_err_src_q, first_err_src_d;

  logic [7:0]          err_new;
  logic [SOURCE_W-1:0] err_src [8];
  logic                a_fire, b_fire, c_fire, d_fire, e_fire;
  logic                a_acq, pack_fire;

  assign a_fire = tl.a_valid && tl.a_ready;
  assign b_fire = tl.b_valid && tl.b_ready;
  assign c_fire = tl.c_valid && tl.c_ready;
  assign d_fire = tl.d_valid && tl.d_ready;
  assign e_fire = tl.e_valid && tl.e_ready;
  assign pack_fire = c_fire && (tl.c_opcode == 3'd4 || tl.c_opcode == 3'd5);

  // Every check reads only *_q state; the order of the updates below defines
  // same-cycle outcomes (E before D on sinks, D before A/C on sources).
  always_comb begin
    src_st_d    = src_st_q;
    age_d       = age_q;
    sink_busy_d = sink_busy_q;
    probe_d     = probe_q;
    err_new     = '0;
    for (int e = 0; e < 8; e++) err_src[e] = '0;
    a_acq       = 1'b0;

    for (int i = 0; i < NumSrc; i++) begin
      if (src_st_q[i] != StIdle && age_q[i] != 16'hffff) age_d[i] = age_q[i] + 16'd1;
    end

    // Descending scan so the lowest timed-out source is the one recorded.
    if (TIMEOUT != 0) begin
      for (int i = NumSrc - 1; i >= 0; i--) begin
        if (src_st_q[i] != StIdle && {16'd0, age_q[i]} == TIMEOUT) begin
          err_new[ErrTimeout] = 1'b1;
          err_src[ErrTimeout] = SOURCE_W'(i);
        end
      end
    end

    if (e_fire) begin
      if (sink_busy_q[tl.e_sink]) begin
        sink_busy_d[tl.e_sink] = 1'b0;
      end else begin
        err_new[ErrUnexpE] = 1'b1;
        err_src[ErrUnexpE] = SOURCE_W'(tl.e_sink);
      end
    end

    if (d_fire) begin
      case (tl.d_opcode)
        3'd4, 3'd5: begin
          if (src_st_q[tl.d_source] == StAcq) begin
            src_st_d[tl.d_source] = StIdle;
            age_d[tl.d_source]    = '0;
          end else begin
            err_new[ErrUnexpD] = 1'b1;
            err_src[ErrUnexpD] = tl.d_source;
          end
          if (!sink_busy_q[tl.d_sink]) begin
            sink_busy_d[tl.d_sink] = 1'b1;
          end else begin
            err_new[ErrDupSink] = 1'b1;
            err_src[ErrDupSink] = SOURCE_W'(tl.d_sink);
          end
        end
        3'd6: begin
          if (src_st_q[tl.d_source] == StRel) begin
            src_st_d[tl.d_source] = StIdle;
            age_d[tl.d_source]    = '0;
          end else begin
            err_new[ErrUnexpD] = 1'b1;
            err_src[ErrUnexpD] = tl.d_source;
          end
        end
        default: begin
          err_new[ErrBadOp] = 1'b1;
          err_src[ErrBadOp] = tl.d_source;
        end
      endcase
    end

    if (a_fire) begin
      if (tl.a_opcode == 3'd6 || tl.a_opcode == 3'd7) begin
        if (src_st_q[tl.a_source] == StIdle) begin
          src_st_d[tl.a_source] = StAcq;
          age_d[tl.a_source]    = '0;
          a_acq                 = 1'b1;
        end else begin
          err_new[ErrDupSrc] = 1'b1;
          err_src[ErrDupSrc] = tl.a_source;
        end
      end else begin
        err_new[ErrBadOp] = 1'b1;
        err_src[ErrBadOp] = tl.a_source;
      end
    end

    if (c_fire) begin
      case (tl.c_opcode)
        3'd6, 3'd7: begin
          // A same-cycle Acquire that already claimed this idle source wins.
          if (src_st_q[tl.c_source] == StIdle && !(a_acq && tl.a_source == tl.c_source)) begin
            src_st_d[tl.c_source] = StRel;
            age_d[tl.c_source]    = '0;
          end else begin
            if (!err_new[ErrDupSrc]) err_src[ErrDupSrc] = tl.c_source;
            err_new[ErrDupSrc] = 1'b1;
          end
        end
        3'd4, 3'd5: ;
        default: begin
          if (!err_new[ErrBadOp]) err_src[ErrBadOp] = tl.c_source;
          err_new[ErrBadOp] = 1'b1;
        end
      endcase
    end

    // A probe and a ProbeAck in the same cycle cancel out.
    if (b_fire && !pack_fire) begin
      if (probe_q == ProbeW'(PROBE_MAX)) err_new[ErrProbeOvf] = 1'b1;
      else                               probe_d = probe_q + ProbeW'(1);
    end else if (!b_fire && pack_fire) begin
      if (probe_q == '0) begin
        err_new[ErrUnexpPa] = 1'b1;
        err_src[ErrUnexpPa] = tl.c_source;
      end else begin
        probe_d = probe_q - ProbeW'(1);
      end
    end
  end

  // Error capture: clear first, then OR in this cycle's errors so a new error
  // arriving together with err_clr is kept and captured.
  always_comb begin
    err_vec_d         = (err_clr ? 8'd0 : err_vec_q) | err_new;
    first_err_valid_d = first_err_valid_q && !err_clr;
    first_err_code_d  = first_err_code_q;
    first_err_src_d   = first_err_src_q;
    if (!first_err_valid_d && (err_new != 8'd0)) begin
      first_err_valid_d = 1'b1;
      for (int i = 7; i >= 0; i--) begin
        if (err_new[i]) first_err_code_d = 3'(i);
      end
      first_err_src_d = err_src[first_err_code_d];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NumSrc; i++) begin
        src_st_q[i] <= StIdle;
        age_q[i]    <= '0;
      end
      sink_busy_q       <= '0;
      probe_q           <= '0;
      err_vec_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_code_q  <= '0;
      first_err_src_q   <= '0;
    end else begin
      src_st_q          <= src_st_d;
      age_q             <= age_d;
      sink_busy_q       <= sink_busy_d;
      probe_q           <= probe_d;
      err_vec_q         <= err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_code_q  <= first_err_code_d;
      first_err_src_q   <= first_err_src_d;
    end
  end

  // Counts are popcounts of registered tables, so they follow reset at once.
  always_comb begin
    acq_cnt  = '0;
    rel_cnt  = '0;
    gack_cnt = '0;
    for (int i = 0; i < NumSrc; i++) begin
      acq_cnt = acq_cnt + SrcCntW'(src_st_q[i] == StAcq);
      rel_cnt = rel_cnt + SrcCntW'(src_st_q[i] == StRel);
    end
    for (int i = 0; i < NumSink; i++) gack_cnt = gack_cnt + SnkCntW'(sink_busy_q[i]);
  end

  assign probe_cnt       = probe_q;
  assign err_vec         = err_vec_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_code  = first_err_code_q;
  assign first_err_src   = first_err_src_q;

  if (PRINT_EN) begin : g_log
    always @(posedge clock) begin
      if (reset_n) begin
        if (a_fire) $write("INTF: core %0d %s [A][%0d %0d] @0x%h source: %0d sink: - data: -\n",
                           core_id, cache_type ? "i$:" : "d$:", tl.a_opcode, tl.a_param,
                           tl.a_address, tl.a_source);
        if (b_fire) $write("INTF: core %0d %s [B][%0d %0d] @0x%h source: - sink: - data: -\n",
                           core_id, cache_type ? "i$:" : "d$:", tl.b_opcode, tl.b_param,
                           tl.b_address);
        if (c_fire) $write("INTF: core %0d %s [C][%0d %0d] @0x%h source: %0d sink: - data: %h\n",
                           core_id, cache_type ? "i$:" : "d$:", tl.c_opcode, tl.c_param,
                           tl.c_address, tl.c_source, tl.c_data);
        if (d_fire) $write("INTF: core %0d %s [D][%0d %0d] @0x- source: %0d sink: %0d data: %h\n",
                           core_id, cache_type ? "i$:" : "d$:", tl.d_opcode, tl.d_param,
                           tl.d_source, tl.d_sink, tl.d_data);
        if (e_fire) $write("INTF: core %0d %s [E][- -] @0x- source: - sink: %0d data: -\n",
                           core_id, cache_type ? "i$:" : "d$:", tl.e_sink);
        if (err_new != 8'd0) $write("ERR: core %0d %s new error bits 0x%h\n",
                                    core_id, cache_type ? "i$:" : "d$:", err_new);
      end
    end
  end

endmodule

// File: tb/tb_tlc_txn_checker.sv
// Scoreboard bench for tlc_txn_checker: each stimulus step pushes the outputs
// it expects after the next clock edge; step() pops and compares them.
module tb_tlc_txn_checker;
  localparam int unsigned SW = 6;
  localparam int unsigned KW = 6;
  localparam int unsigned AW = 36;
  localparam int unsigned DW = 256;
  localparam int unsigned PM = 15;
  localparam int unsigned TO = 20;

  localparam int SelErr  = 0;
  localparam int SelFev  = 1;
  localparam int SelFec  = 2;
  localparam int SelFes  = 3;
  localparam int SelAcq  = 4;
  localparam int SelRel  = 5;
  localparam int SelGack = 6;
  localparam int SelPrb  = 7;

  logic          clock;
  logic          reset_n;
  logic          err_clr;
  logic [7:0]    err_vec;
  logic          first_err_valid;
  logic [2:0]    first_err_code;
  logic [SW-1:0] first_err_src;
  logic [SW:0]   acq_cnt;
  logic [SW:0]   rel_cnt;
  logic [KW:0]   gack_cnt;
  logic [3:0]    probe_cnt;

  typedef struct {
    int          sel;
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  tlc_txn_checker_if #(.SOURCE_W(SW), .SINK_W(KW), .ADDR_W(AW), .DATA_W(DW)) tl_if ();

  tlc_txn_checker #(
    .SOURCE_W (SW),
    .SINK_W   (KW),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .PROBE_MAX(PM),
    .TIMEOUT  (TO),
    .PRINT_EN (1'b0)
  ) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .core_id        (64'd0),
    .cache_type     (1'b0),
    .tl             (tl_if),
    .err_clr        (err_clr),
    .err_vec        (err_vec),
    .first_err_valid(first_err_valid),
    .first_err_code (first_err_code),
    .first_err_src  (first_err_src),
    .acq_cnt        (acq_cnt),
    .rel_cnt        (rel_cnt),
    .gack_cnt       (gack_cnt),
    .probe_cnt      (probe_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SelErr:  return 64'(err_vec);
      SelFev:  return 64'(first_err_valid);
      SelFec:  return 64'(first_err_code);
      SelFes:  return 64'(first_err_src);
      SelAcq:  return 64'(acq_cnt);
      SelRel:  return 64'(rel_cnt);
      SelGack: return 64'(gack_cnt);
      default: return 64'(probe_cnt);
    endcase
  endfunction

  task automatic expect_out(input int sel, input string tag, input logic [63:0] exp);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_err(input string tag, input logic [7:0] ev, input logic [2:0] code,
                            input logic [SW-1:0] src);
    expect_out(SelErr, {tag, "_vec"}, 64'(ev));
    expect_out(SelFev, {tag, "_fev"}, 64'(1));
    expect_out(SelFec, {tag, "_code"}, 64'(code));
    expect_out(SelFes, {tag, "_src"}, 64'(src));
  endtask

  task automatic expect_all_zero(input string tag);
    for (int s = SelErr; s <= SelPrb; s++) expect_out(s, $sformatf("%s_sel%0d", tag, s), 64'd0);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle_all();
    tl_if.a_valid = 1'b0; tl_if.b_valid = 1'b0; tl_if.c_valid = 1'b0;
    tl_if.d_valid = 1'b0; tl_if.e_valid = 1'b0;
    tl_if.a_ready = 1'b1; tl_if.b_ready = 1'b1; tl_if.c_ready = 1'b1;
    tl_if.d_ready = 1'b1; tl_if.e_ready = 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle_all();
    drain();
  endtask

  task automatic drv_a(input logic [2:0] op, input logic [SW-1:0] src);
    tl_if.a_valid = 1'b1; tl_if.a_opcode = op; tl_if.a_param = 3'd1;
    tl_if.a_source = src; tl_if.a_address = AW'(src) << 6;
  endtask

  task automatic drv_b();
    tl_if.b_valid = 1'b1; tl_if.b_opcode = 3'd6; tl_if.b_param = 2'd1;
    tl_if.b_address = AW'('h1000);
  endtask

  task automatic drv_c(input logic [2:0] op, input logic [SW-1:0] src);
    tl_if.c_valid = 1'b1; tl_if.c_opcode = op; tl_if.c_param = 3'd0;
    tl_if.c_source = src; tl_if.c_address = AW'(src) << 6; tl_if.c_data = DW'($urandom);
  endtask

  task automatic drv_d(input logic [2:0] op, input logic [SW-1:0] src, input logic [KW-1:0] snk);
    tl_if.d_valid = 1'b1; tl_if.d_opcode = op; tl_if.d_param = 2'd0;
    tl_if.d_source = src; tl_if.d_sink = snk; tl_if.d_data = DW'($urandom);
  endtask

  task automatic drv_e(input logic [KW-1:0] snk);
    tl_if.e_valid = 1'b1; tl_if.e_sink = snk;
  endtask

  task automatic do_reset(input string tag);
    idle_all();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expect_all_zero(tag);
    drain();
    reset_n = 1'b1;
  endtask

  initial begin
    tl_if.a_opcode = '0; tl_if.a_param = '0; tl_if.a_source = '0; tl_if.a_address = '0;
    tl_if.b_opcode = '0; tl_if.b_param = '0; tl_if.b_address = '0;
    tl_if.c_opcode = '0; tl_if.c_param = '0; tl_if.c_source = '0; tl_if.c_address = '0;
    tl_if.c_data = '0;
    tl_if.d_opcode = '0; tl_if.d_param = '0; tl_if.d_source = '0; tl_if.d_sink = '0;
    tl_if.d_data = '0; tl_if.e_sink = '0;
    do_reset("rst0");

    // Acquire/Grant/GrantAck round trip; a valid without ready does not fire.
    tl_if.a_ready = 1'b0; drv_a(3'd6, 6'd3); tl_if.a_ready = 1'b0;
    expect_out(SelAcq, "noready_acq", 64'd0); step();
    drv_a(3'd6, 6'd3);
    expect_out(SelAcq, "acq1_cnt", 64'd1); step();
    drv_d(3'd5, 6'd3, 6'd5);
    expect_out(SelAcq, "gnt_acq", 64'd0); expect_out(SelGack, "gnt_gack", 64'd1); step();
    drv_e(6'd5);
    expect_out(SelGack, "gack_gack", 64'd0); expect_out(SelErr, "gack_err", 64'd0); step();

    // Release/ReleaseAck and a stray ReleaseAck.
    drv_c(3'd7, 6'd2);
    expect_out(SelRel, "rel_cnt1", 64'd1); step();
    drv_d(3'd6, 6'd2, 6'd0);
    expect_out(SelRel, "rel_cnt0", 64'd0); expect_out(SelErr, "rel_err0", 64'd0); step();
    drv_d(3'd6, 6'd2, 6'd0);
    expect_err("stray_ra", 8'h02, 3'd1, 6'd2); step();

    // Duplicate AcquirePerm on one source.
    do_reset("rst1");
    drv_a(3'd7, 6'd7);
    expect_out(SelAcq, "dup_first", 64'd1); step();
    drv_a(3'd7, 6'd7);
    expect_err("dup", 8'h01, 3'd0, 6'd7); expect_out(SelAcq, "dup_acq", 64'd1); step();

    // Probe counting, overflow and B+ProbeAck cancellation.
    do_reset("rst2");
    drv_c(3'd4, 6'd9);
    expect_err("pa_none", 8'h10, 3'd4, 6'd9); step();
    for (int i = 0; i < 15; i++) begin
      drv_b();
      expect_out(SelPrb, $sformatf("probe_%0d", i), 64'(i + 1)); step();
    end
    drv_b();
    expect_out(SelPrb, "probe_ovf_cnt", 64'd15); expect_out(SelErr, "probe_ovf_err", 64'h30);
    step();
    drv_b(); drv_c(3'd5, 6'd0);
    expect_out(SelPrb, "probe_both_cnt", 64'd15);
    expect_out(SelErr, "probe_both_err", 64'h30); step();

    // Timeout 21 cycles after an unanswered Acquire, then clear.
    do_reset("rst3");
    drv_a(3'd6, 6'd1); step();
    for (int i = 1; i <= 20; i++) begin
      expect_out(SelErr, $sformatf("to_wait_%0d", i), 64'd0); step();
    end
    expect_err("to", 8'h80, 3'd7, 6'd1); step();
    err_clr = 1'b1;
    expect_out(SelErr, "clr_err", 64'd0); expect_out(SelFev, "clr_fev", 64'd0); step();
    repeat (3) begin
      expect_out(SelErr, "to_norefire", 64'd0); step();
    end
    expect_out(SelAcq, "to_acq", 64'd1); step();

    // Same-cycle source and sink collisions.
    do_reset("rst4");
    drv_a(3'd6, 6'd4); step();
    drv_a(3'd6, 6'd4); drv_d(3'd4, 6'd4, 6'd3);
    expect_err("a_d_same", 8'h01, 3'd0, 6'd4);
    expect_out(SelAcq, "a_d_acq", 64'd0); expect_out(SelGack, "a_d_gack", 64'd1); step();
    drv_a(3'd6, 6'd4);
    expect_out(SelAcq, "reacq", 64'd1); step();
    drv_d(3'd4, 6'd4, 6'd8); drv_e(6'd8);
    expect_err("d_e_same", 8'h09, 3'd0, 6'd4); expect_out(SelGack, "d_e_gack", 64'd2); step();

    // Bad opcode, then asynchronous reset mid-transaction.
    do_reset("rst5");
    drv_a(3'd0, 6'd5);
    expect_err("badop", 8'h40, 3'd6, 6'd5); step();
    drv_a(3'd6, 6'd10); step();
    drv_a(3'd6, 6'd11); step();
    drv_a(3'd6, 6'd12); step();
    drv_d(3'd4, 6'd12, 6'd9);
    expect_out(SelAcq, "pre_rst_acq", 64'd2); expect_out(SelGack, "pre_rst_gack", 64'd1);
    step();
    #2;
    reset_n = 1'b0;
    #1;
    expect_all_zero("async_rst");
    drain();
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
